// File: rtl/mem_responder.sv
// mem_responder: data-side memory responder for the multicycle CPU.
// Ports: clk/reset (sync, active-high); req/wr/size/sign_ext/addr/wdata request
// fields sampled in IDLE; rdata/ready/err registered response, one-cycle pulse.
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic [1:0]            off_q, off_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_rd;
  logic [31:0] merged;
  logic        mem_we;
  logic        illegal;

  // Address bits above the array index alias and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                          input logic [1:0] off, input logic se);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      2'b00:   extract = se ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
      2'b01:   extract = se ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = word;
    case (sz)
      2'b00:   m[{off, 3'b000} +: 8]      = wd[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    merge = m;
  endfunction

  assign illegal = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);

  assign mem_rd = mem_q[idx_q];
  assign merged = merge(buf_q, wdata_q, size_q, off_q);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    rdata_d = 32'h0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          sext_d  = sign_ext;
          off_d   = addr[1:0];
          idx_d   = addr[DEPTH_LOG2+1:2];
          wdata_d = wdata;
          if (illegal) begin
            // Rejected without touching the array.
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        buf_d = mem_rd;
        cnt_d = 4'd0;
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
        end else if (wr_q) begin
          state_d = WR;
        end else begin
          // Buffer is being loaded this edge, so extract from the array directly.
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = extract(mem_rd, size_q, off_q, sext_q);
        end
      end
      WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          if (wr_q) begin
            state_d = WR;
          end else begin
            state_d = RESP;
            ready_d = 1'b1;
            rdata_d = extract(buf_q, size_q, off_q, sext_q);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR: begin
        mem_we  = 1'b1;
        state_d = RESP;
        ready_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Array is not cleared by reset; a reset coinciding with WR drops the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx_q] <= merged;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic        wr = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata0, rdata3;
  logic        ready0, ready3, err0, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst), .req(req0), .wr(wr), .size(size), .sign_ext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0));

  mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst), .req(req3), .wr(wr), .size(size), .sign_ext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3));

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Issues one request from an IDLE cycle (called #1 after a rising edge),
  // returns the cycle in which ready appeared, then steps into the next IDLE cycle.
  task automatic do_req(input bit slow, input bit w, input logic [1:0] sz, input bit se,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic e,
                        output bit pulse_ok);
    wr = w; size = sz; sext = se; addr = a; wdata = d;
    if (slow) req3 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req3 = 1'b0;
    // Scrambled fields after sampling must not matter.
    wr = ~w; size = ~sz; sext = ~se; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A;
    lat = 1;
    while (!(slow ? ready3 : ready0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = slow ? rdata3 : rdata0;
    e  = slow ? err3 : err0;
    @(posedge clk); #1;
    pulse_ok = slow ? (ready3 === 1'b0 && rdata3 === 32'h0 && err3 === 1'b0)
                    : (ready0 === 1'b0 && rdata0 === 32'h0 && err0 === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err0); end
    checks++; if ({ready3, err3, rdata3} !== 34'h0) begin errors++; $display("FAIL reset_slow got %b%b %h exp 0", ready3, err3, rdata3); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_round_trip();
    int lat; logic [31:0] rd; logic e; bit p;
    do_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, e, p);
    checks++; if (lat !== 3) begin errors++; $display("FAIL st_word_lat got %0d exp 3", lat); end
    checks++; if ({e, rd} !== 33'h0) begin errors++; $display("FAIL st_word_resp got %b %h exp 0 0", e, rd); end
    checks++; if (!p) begin errors++; $display("FAIL st_word_pulse got held exp one-cycle"); end
    do_req(0, 0, 2'b10, 0, 32'h10, 32'h0, lat, rd, e, p);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ld_word_lat got %0d exp 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word got %h exp deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL ld_word_err got %b exp 0", e); end
    checks++; if (!p) begin errors++; $display("FAIL ld_word_pulse got held exp one-cycle"); end
    do_req(0, 0, 2'b10, 0, 32'h410, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_alias got %h exp deadbeef", rd); end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic e; bit p;
    do_req(0, 1, 2'b10, 0, 32'h20, 32'h11223344, lat, rd, e, p);
    do_req(0, 1, 2'b00, 0, 32'h21, 32'h123456AA, lat, rd, e, p);
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL st_byte got lat %0d err %b exp 3 0", lat, e); end
    do_req(0, 0, 2'b10, 0, 32'h20, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_rmw got %h exp 1122aa44", rd); end
    do_req(0, 0, 2'b00, 1, 32'h21, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL ld_byte_sx got %h exp ffffffaa", rd); end
    do_req(0, 0, 2'b00, 0, 32'h21, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL ld_byte_zx got %h exp 000000aa", rd); end
    do_req(0, 0, 2'b00, 1, 32'h23, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL ld_byte3 got %h exp 00000011", rd); end
  endtask

  task automatic test_half();
    int lat; logic [31:0] rd; logic e; bit p;
    do_req(0, 1, 2'b01, 0, 32'h22, 32'hABCD8001, lat, rd, e, p);
    do_req(0, 0, 2'b10, 0, 32'h20, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'h8001AA44) begin errors++; $display("FAIL half_rmw got %h exp 8001aa44", rd); end
    do_req(0, 0, 2'b01, 1, 32'h22, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL ld_half_hi got %h exp ffff8001", rd); end
    do_req(0, 0, 2'b01, 1, 32'h20, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'hFFFFAA44) begin errors++; $display("FAIL ld_half_lo got %h exp ffffaa44", rd); end
    do_req(0, 0, 2'b01, 0, 32'h22, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL ld_half_zx got %h exp 00008001", rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic e; bit p;
    do_req(0, 1, 2'b10, 0, 32'h04, 32'hCAFEF00D, lat, rd, e, p);
    do_req(0, 0, 2'b10, 0, 32'h13, 32'h0, lat, rd, e, p);
    checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_word_mis got lat %0d err %b rd %h exp 1 1 0", lat, e, rd); end
    checks++; if (!p) begin errors++; $display("FAIL err_pulse got held exp one-cycle"); end
    do_req(0, 1, 2'b01, 0, 32'h05, 32'hFFFFFFFF, lat, rd, e, p);
    checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_half_mis got lat %0d err %b rd %h exp 1 1 0", lat, e, rd); end
    do_req(0, 1, 2'b11, 0, 32'h04, 32'h00000000, lat, rd, e, p);
    checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL err_size_st got lat %0d err %b exp 1 1", lat, e); end
    do_req(0, 0, 2'b11, 0, 32'h04, 32'h0, lat, rd, e, p);
    checks++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_size_ld got lat %0d err %b rd %h exp 1 1 0", lat, e, rd); end
    do_req(0, 0, 2'b10, 0, 32'h04, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL err_unchanged got %h err %b exp cafef00d 0", rd, e); end
  endtask

  task automatic test_slow_timing();
    int lat; logic [31:0] rd; logic e; bit p;
    do_req(1, 1, 2'b10, 0, 32'h10, 32'h0BADCAFE, lat, rd, e, p);
    checks++; if (lat !== 6) begin errors++; $display("FAIL slow_st_lat got %0d exp 6", lat); end
    do_req(1, 0, 2'b10, 0, 32'h10, 32'h0, lat, rd, e, p);
    checks++; if (lat !== 5) begin errors++; $display("FAIL slow_ld_lat got %0d exp 5", lat); end
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL slow_ld got %h exp 0badcafe", rd); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, first = -1, second = -1;
    logic [31:0] rd2 = 32'h0;
    wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10; wdata = 32'h0;
    req3 = 1'b1;
    while (second < 0 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready3) begin
        if (first < 0) first = cyc;
        else begin second = cyc; rd2 = rdata3; req3 = 1'b0; end
      end
    end
    req3 = 1'b0;
    checks++; if (first !== 5) begin errors++; $display("FAIL b2b_first got %0d exp 5", first); end
    checks++; if (second !== 11) begin errors++; $display("FAIL b2b_second got %0d exp 11", second); end
    checks++; if (rd2 !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_data got %h exp 0badcafe", rd2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic e; bit p;
    int pulses = 0;
    do_req(1, 1, 2'b10, 0, 32'h30, 32'h0, lat, rd, e, p);
    wr = 1'b1; size = 2'b10; sext = 1'b0; addr = 32'h30; wdata = 32'h12345678;
    req3 = 1'b1;
    @(posedge clk); #1;           // cycle 1: RD
    req3 = 1'b0;
    if (ready3) pulses++;
    @(posedge clk); #1;           // cycle 2: WAIT
    if (ready3) pulses++;
    @(posedge clk); #1;           // cycle 3: WAIT
    if (ready3) pulses++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ready3, err3, rdata3} !== 34'h0) begin errors++; $display("FAIL rst_mid_outs got %b%b %h exp 0", ready3, err3, rdata3); end
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready3) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_pulse got %0d exp 0", pulses); end
    do_req(1, 0, 2'b10, 0, 32'h30, 32'h0, lat, rd, e, p);
    checks++; if (rd !== 32'h0 || lat !== 5) begin errors++; $display("FAIL rst_mid_data got %h lat %0d exp 0 5", rd, lat); end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_byte();
    test_half();
    test_errors();
    test_slow_timing();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
